// File: rtl/led_ctrl_pkg.sv
// Shared mode codes and helpers for the LED pattern controller.
// Codes 6 and 7 are reserved and rejected by is_valid_mode.
package led_ctrl_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_OFF     = 3'd0;
    localparam mode_t MODE_ON      = 3'd1;
    localparam mode_t MODE_BLINK   = 3'd2;
    localparam mode_t MODE_WATER_L = 3'd3;
    localparam mode_t MODE_WATER_R = 3'd4;
    localparam mode_t MODE_BREATHE = 3'd5;

    function automatic logic is_valid_mode(input mode_t m);
        return (m <= MODE_BREATHE);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running 0..CNT_MAX counter with a registered one-cycle step tick.
// The tick is high while the counter sits at CNT_MAX, so the consumer steps on the wrap edge.
module tick_gen #(
    parameter int unsigned CNT_MAX = 24_999_999,
    parameter int          CNT_W   = 25
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LP_PRE = CNT_W'(CNT_MAX - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // clr restarts the pattern phase from zero, even while en is low
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_cnt  <= (r_cnt == LP_MAX) ? '0 : r_cnt + CNT_W'(1);
            r_tick <= (r_cnt == LP_PRE);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_mode_ctrl.sv
// Multi-channel LED pattern controller: off, on, blink, running light left/right and PWM breathe.
// Prescaler lives in tick_gen; mode, pattern and PWM state are held here.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int          LED_W    = 4,
    parameter int unsigned CNT_MAX  = 24_999_999,
    parameter int          CNT_W    = 25,
    parameter int unsigned PWM_MAX  = 999,
    parameter int          PWM_W    = 10,
    parameter mode_t       RST_MODE = MODE_BLINK
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic [2:0]       mode_in,
    input  logic             mode_vld,
    output logic [LED_W-1:0] led_out,
    output logic [2:0]       cur_mode
);

    localparam logic [PWM_W-1:0] LP_PWM_MAX = PWM_W'(PWM_MAX);
    localparam logic [PWM_W-1:0] LP_PWM_PRE = PWM_W'(PWM_MAX - 1);
    localparam logic [PWM_W-1:0] LP_PWM_ONE = PWM_W'(1);

    function automatic logic [LED_W-1:0] init_pattern(input mode_t m);
        logic [LED_W-1:0] p;
        p = '0;
        case (m)
            MODE_ON:      p = '1;
            MODE_WATER_L: p[0] = 1'b1;
            MODE_WATER_R: p[LED_W-1] = 1'b1;
            default:      p = '0;
        endcase
        return p;
    endfunction

    localparam logic [LED_W-1:0] LP_RST_LED = init_pattern(RST_MODE);

    mode_t            r_mode;
    logic [LED_W-1:0] r_led;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_dir_up;

    mode_t            w_mode_nxt;
    logic [LED_W-1:0] w_led_nxt;
    logic [PWM_W-1:0] w_pwm_nxt;
    logic [PWM_W-1:0] w_duty_nxt;
    logic             w_dir_nxt;
    logic             w_load;
    logic             w_tick;
    logic             w_pwm_wrap;

    assign w_load     = mode_vld && is_valid_mode(mode_in);
    assign w_pwm_wrap = (r_pwm_cnt == LP_PWM_MAX);

    tick_gen #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .clr       (w_load),
        .tick      (w_tick)
    );

    // A mode load wins over a coincident tick; otherwise everything advances only while en is high.
    // Duty turns around one step early so each endpoint is held for a single PWM period.
    always_comb begin
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_pwm_nxt  = r_pwm_cnt;
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir_up;

        if (w_load) begin
            w_mode_nxt = mode_in;
            w_led_nxt  = init_pattern(mode_in);
            w_pwm_nxt  = '0;
            w_duty_nxt = '0;
            w_dir_nxt  = 1'b1;
        end else if (en) begin
            w_pwm_nxt = w_pwm_wrap ? '0 : r_pwm_cnt + LP_PWM_ONE;

            if (w_pwm_wrap) begin
                if (r_dir_up) begin
                    w_duty_nxt = r_duty + LP_PWM_ONE;
                    if (r_duty == LP_PWM_PRE) begin
                        w_dir_nxt = 1'b0;
                    end
                end else begin
                    w_duty_nxt = r_duty - LP_PWM_ONE;
                    if (r_duty == LP_PWM_ONE) begin
                        w_dir_nxt = 1'b1;
                    end
                end
            end

            case (r_mode)
                MODE_BLINK: begin
                    if (w_tick) begin
                        w_led_nxt = ~r_led;
                    end
                end
                MODE_WATER_L: begin
                    if (w_tick) begin
                        w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
                    end
                end
                MODE_WATER_R: begin
                    if (w_tick) begin
                        w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
                    end
                end
                MODE_BREATHE: begin
                    w_led_nxt = {LED_W{(r_pwm_cnt < r_duty)}};
                end
                default: begin
                    w_led_nxt = r_led;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mode    <= RST_MODE;
            r_led     <= LP_RST_LED;
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_dir_up  <= 1'b1;
        end else begin
            r_mode    <= w_mode_nxt;
            r_led     <= w_led_nxt;
            r_pwm_cnt <= w_pwm_nxt;
            r_duty    <= w_duty_nxt;
            r_dir_up  <= w_dir_nxt;
        end
    end

    assign led_out  = r_led;
    assign cur_mode = r_mode;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl: directed pattern checks plus randomized traffic against
// a model that derives the LEDs from the mode and the number of enabled edges since it was loaded.
module tb_led_mode_ctrl;

    localparam int LED_W    = 4;
    localparam int CNT_MAX  = 4;
    localparam int CNT_W    = 3;
    localparam int PWM_MAX  = 3;
    localparam int PWM_W    = 2;
    localparam int RST_MODE = 2;
    localparam int ALL_ON   = (1 << LED_W) - 1;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             en        = 1'b1;
    logic [2:0]       mode_in   = 3'd0;
    logic             mode_vld  = 1'b0;
    logic [LED_W-1:0] led_out;
    logic [2:0]       cur_mode;

    int testsRun  = 0;
    int failCount = 0;
    logic checkEn = 1'b0;

    int mMode = RST_MODE;
    int mK    = 0;

    led_mode_ctrl #(
        .LED_W    (LED_W),
        .CNT_MAX  (CNT_MAX),
        .CNT_W    (CNT_W),
        .PWM_MAX  (PWM_MAX),
        .PWM_W    (PWM_W),
        .RST_MODE (3'd2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .mode_in   (mode_in),
        .mode_vld  (mode_vld),
        .led_out   (led_out),
        .cur_mode  (cur_mode)
    );

    always #5 sys_clk = ~sys_clk;

    // Duty of PWM period q: a triangle 0..PWM_MAX..0 with period 2*PWM_MAX
    function automatic int triDuty(input int q);
        int t;
        t = q % (2 * PWM_MAX);
        return (t <= PWM_MAX) ? t : 2 * PWM_MAX - t;
    endfunction

    // Expected LEDs after k enabled edges since the mode was loaded (or reset released)
    function automatic int expLed(input int m, input int k);
        int s;
        s = k / (CNT_MAX + 1);
        case (m)
            1:       return ALL_ON;
            2:       return (s % 2 == 1) ? ALL_ON : 0;
            3:       return 1 << (s % LED_W);
            4:       return (1 << (LED_W - 1)) >> (s % LED_W);
            5: begin
                if (k == 0) return 0;
                return (((k - 1) % (PWM_MAX + 1)) < triDuty((k - 1) / (PWM_MAX + 1))) ? ALL_ON : 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun = testsRun + 1;
        if (act != exp) begin
            failCount = failCount + 1;
            if (failCount <= 30) begin
                $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic vldV, input logic [2:0] modeV);
        en       = enV;
        mode_vld = vldV;
        mode_in  = modeV;
    endtask

    task automatic loadMode(input logic [2:0] m);
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b1, m);
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0, m);
    endtask

    // Reference model: a valid strobe restarts the edge count, en advances it
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mMode <= RST_MODE;
            mK    <= 0;
        end else if (mode_vld && mode_in <= 3'd5) begin
            mMode <= int'(mode_in);
            mK    <= 0;
        end else if (en) begin
            mK <= mK + 1;
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model
    always @(negedge sys_clk) begin
        if (checkEn) begin
            checkOutput("model_led", int'(led_out), expLed(mMode, mK));
            checkOutput("model_mode", int'(cur_mode), mMode);
        end
    end

    initial begin : stimulus
        int walkL[4];
        int walkR[4];
        int breatheHi[8];
        int hi;
        int n;

        walkL     = '{2, 4, 8, 1};
        walkR     = '{4, 2, 1, 8};
        breatheHi = '{0, 1, 2, 3, 2, 1, 0, 1};

        applyStimulus(1'b1, 1'b0, 3'd0);
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_led", int'(led_out), 0);
        checkOutput("reset_mode", int'(cur_mode), 2);
        sys_rst_n = 1'b1;
        checkEn   = 1'b1;

        // Default BLINK: first toggle at edge 5, second at edge 10
        repeat (4) @(negedge sys_clk);
        checkOutput("blink_edge4", int'(led_out), 0);
        @(negedge sys_clk);
        checkOutput("blink_edge5", int'(led_out), 15);
        repeat (5) @(negedge sys_clk);
        checkOutput("blink_edge10", int'(led_out), 0);

        loadMode(3'd3);
        checkOutput("waterL_init", int'(led_out), 1);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge sys_clk);
            checkOutput("waterL_step", int'(led_out), walkL[i]);
        end

        loadMode(3'd4);
        checkOutput("waterR_init", int'(led_out), 8);
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge sys_clk);
            checkOutput("waterR_step", int'(led_out), walkR[i]);
        end

        // Reserved code mid-rotation must not disturb mode or cadence
        loadMode(3'd3);
        repeat (2) @(negedge sys_clk);
        applyStimulus(1'b1, 1'b1, 3'd6);
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("reserved_mode", int'(cur_mode), 3);
        repeat (2) @(negedge sys_clk);
        checkOutput("reserved_cadence", int'(led_out), 2);

        loadMode(3'd5);
        checkOutput("breathe_init", int'(led_out), 0);
        for (int p = 0; p < 8; p++) begin
            hi = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge sys_clk);
                hi = hi + int'(led_out[0]);
            end
            checkOutput("breathe_period_hi", hi, breatheHi[p]);
        end

        // Freeze BLINK for 7 edges: first toggle moves from edge 5 to edge 12
        loadMode(3'd2);
        repeat (2) @(negedge sys_clk);
        applyStimulus(1'b0, 1'b0, 3'd0);
        repeat (7) @(negedge sys_clk);
        checkOutput("freeze_hold", int'(led_out), 0);
        applyStimulus(1'b1, 1'b0, 3'd0);
        n = 9;
        while (led_out == 4'b0000 && n < 40) begin
            @(negedge sys_clk);
            n = n + 1;
        end
        checkOutput("freeze_toggle_edge", n, 12);

        // Strobe ON on the edge that would toggle 1111 back to 0000
        repeat (4) @(negedge sys_clk);
        applyStimulus(1'b1, 1'b1, 3'd1);
        @(negedge sys_clk);
        applyStimulus(1'b1, 1'b0, 3'd0);
        checkOutput("load_over_tick_led", int'(led_out), 15);
        checkOutput("load_over_tick_mode", int'(cur_mode), 1);
        repeat (5) @(negedge sys_clk);
        checkOutput("on_steady", int'(led_out), 15);

        // Asynchronous reset between edges
        loadMode(3'd3);
        repeat (7) @(negedge sys_clk);
        checkOutput("pre_reset_led", int'(led_out), 2);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_reset_led", int'(led_out), 0);
        checkOutput("async_reset_mode", int'(cur_mode), 2);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Randomized traffic, inputs changed just after the active edge
        for (int i = 0; i < 4000; i++) begin
            @(posedge sys_clk);
            #1;
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                          3'($urandom_range(0, 7)));
            sys_rst_n = ($urandom_range(0, 499) != 0);
        end
        @(posedge sys_clk);
        #1;
        applyStimulus(1'b1, 1'b0, 3'd0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Multi-channel LED pattern controller. It is the parametrised successor of the single-LED fixed-period blinker.
- Drives LED_W LEDs in one of six runtime-selectable modes: off, on, blink, running light left, running light right, breathe (PWM).
- Sits between board key/debounce or UART command logic (mode select) and the LED pins.
- Step rate is set by a prescaler.

Parameters:
LED_W, 4, number of LED outputs (>=2)
CNT_MAX, 25'd24_999_999, prescaler terminal count; one pattern step every CNT_MAX+1 clocks (>=1)
CNT_W, 25, prescaler counter width; must hold CNT_MAX
PWM_MAX, 10'd999, PWM terminal count; PWM period is PWM_MAX+1 clocks (>=1)
PWM_W, 10, PWM counter and duty width; must hold PWM_MAX
RST_MODE, 3'd2, mode loaded at reset (BLINK)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous reset, active low
en  in  1  run enable; low freezes all counters and holds led_out
mode_in  in  3  requested mode code
mode_vld  in  1  single-cycle strobe; samples mode_in
led_out  out  LED_W  LED drive, registered
cur_mode  out  3  currently active mode, registered

Behaviour:
- Clocking and reset: sys_clk is the clock. sys_rst_n is asynchronous and active low.
- Reset values:
  - led_out = mode init pattern of RST_MODE (0 for BLINK).
  - cur_mode = RST_MODE.
  - Prescaler, PWM counter and duty = 0; breathe direction = up.
- Prescaler:
  - cnt counts 0..CNT_MAX and wraps to 0 while en=1.
  - tick is a register, set on the edge where cnt==CNT_MAX-1. It is therefore high for exactly one cycle, coincident with cnt==CNT_MAX.
- Pattern step: pattern registers update on the edge where tick=1. The first step lands CNT_MAX+1 edges after reset release.
- Mode codes and init patterns:
  - 0 OFF: all 0, no stepping.
  - 1 ON: all 1, no stepping.
  - 2 BLINK: init all 0; each step inverts all bits.
  - 3 WATER_L: init one-hot bit0; each step rotates left, MSB wraps to bit0.
  - 4 WATER_R: init one-hot MSB; each step rotates right, bit0 wraps to MSB.
  - 5 BREATHE: see below.
  - 6, 7: reserved. The strobe is ignored and cur_mode is unchanged.
- Mode load:
  - On mode_vld=1 with a valid code, the next edge sets cur_mode.
  - The same edge loads the init pattern into led_out and clears cnt, tick, PWM counter and duty, and sets direction = up.
  - Re-requesting the current mode restarts it identically.
  - mode_vld is accepted regardless of en.
  - mode_vld has priority over a coincident tick.
- BREATHE:
  - pwm_cnt counts 0..PWM_MAX and wraps, independent of the prescaler.
  - On each wrap, duty moves by 1 in the current direction. At duty==PWM_MAX the direction flips to down; at duty==0 it flips to up. The endpoint value is held for exactly one PWM period.
  - led_out is all bits = (pwm_cnt < duty), registered, with 1-cycle latency. duty=0 gives fully off; duty=PWM_MAX gives on for PWM_MAX of PWM_MAX+1 clocks.
  - Full breathe cycle is 2*PWM_MAX*(PWM_MAX+1) clocks.
- en=0: cnt, tick, pwm_cnt, duty and direction hold; led_out holds. Resuming continues exactly where it stopped, with no lost or extra step.
- Asserting sys_rst_n mid-pattern returns immediately and asynchronously to the reset values.
- Arithmetic: all counters are unsigned. The duty compare is done at PWM_W bits, with no overflow past PWM_MAX.

Decomposition:
- Package led_ctrl_pkg holds:
  - 3-bit mode localparams MODE_OFF/ON/BLINK/WATER_L/WATER_R/BREATHE.
  - An is_valid_mode function.
- Sub-module tick_gen holds the prescaler.
  - Parameters: CNT_MAX, CNT_W.
  - Ports: sys_clk, sys_rst_n, en, clr, tick.
- The pattern/PWM logic stays in the top.

Test Plan:
- Reset, CNT_MAX=4, LED_W=4, default mode: led_out=4'b0000 and cur_mode=2 → led_out=4'b1111 at edge 5 after release, 4'b0000 at edge 10.
- mode_vld with mode_in=3, CNT_MAX=4: led_out=4'b0001 next edge → 0010, 0100, 1000, 0001 at 5-cycle spacing. Repeat with mode 4: 1000, 0100, 0010, 0001, 1000.
- mode_in=6 strobed while in mode 3: cur_mode stays 3, rotation cadence undisturbed.
- BREATHE with PWM_MAX=3: duty sequence per 4-clock period is 0,1,2,3,2,1,0,1. High-count per period equals duty, except duty 3 gives 3 of 4. led_out is 0 while duty=0.
- Mode 2, drop en for 7 cycles mid-count: led_out frozen, next toggle delayed by exactly 7 cycles. mode_vld=1 for mode 1 coincident with tick: led_out=4'b1111, no toggle applied.
- Assert sys_rst_n low mid-WATER_L between clock edges: led_out=0 and cur_mode=2 asynchronously, before the next edge.
